// File: rtl/bram_tdp_pipe_if.sv
// rtl/bram_tdp_pipe_if.sv - dual-port request/response bundle for bram_tdp_pipe
interface bram_tdp_pipe_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic                 a_en;
    logic                 a_we;
    logic [AW-1:0]        a_addr;
    logic signed [DW-1:0] a_din;
    logic signed [DW-1:0] a_dout;
    logic                 a_valid;

    logic                 b_en;
    logic                 b_we;
    logic [AW-1:0]        b_addr;
    logic signed [DW-1:0] b_din;
    logic signed [DW-1:0] b_dout;
    logic                 b_valid;

    modport master (
        output a_en, a_we, a_addr, a_din,
        input  a_dout, a_valid,
        output b_en, b_we, b_addr, b_din,
        input  b_dout, b_valid
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din,
        output a_dout, a_valid,
        input  b_en, b_we, b_addr, b_din,
        output b_dout, b_valid
    );
endinterface

// File: rtl/bram_tdp_pipe.sv
// rtl/bram_tdp_pipe.sv - true dual-port RAM with pipelined reads and a zero-fill engine
module bram_tdp_pipe #(
    parameter int DW             = 16,
    parameter int DEPTH          = 1024,
    parameter int AW             = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
    parameter int RD_LAT         = 1,
    parameter int WR_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    bram_tdp_pipe_if.slave bus,
    input  logic           clr_req,
    output logic           busy,
    output logic           collision
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t               state, state_nxt;
    logic [AW-1:0]        clr_cnt, clr_cnt_nxt;
    logic                 init_pend;
    logic signed [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            clr_cnt   <= '0;
            init_pend <= (CLEAR_ON_RESET != 0);
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            init_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req || init_pend) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + AW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_CLEAR);

    logic                 a_acc, a_inr, a_wr, a_rd;
    logic                 b_acc, b_inr, b_wr, b_rd;
    logic signed [DW-1:0] a_rdata, b_rdata;

    assign a_acc = bus.a_en && !busy;
    assign b_acc = bus.b_en && !busy;
    assign a_inr = {1'b0, bus.a_addr} < DEPTH_W;
    assign b_inr = {1'b0, bus.b_addr} < DEPTH_W;
    assign a_wr  = a_acc && bus.a_we && a_inr;
    assign b_wr  = b_acc && bus.b_we && b_inr;
    // NO_CHANGE suppresses the response of a writing access entirely
    assign a_rd  = a_acc && !(bus.a_we && WR_MODE == 2);
    assign b_rd  = b_acc && !(bus.b_we && WR_MODE == 2);

    // The array read sees the pre-edge contents, which gives READ_FIRST and the cross-port old-data rule
    assign a_rdata = !a_inr ? '0 : (bus.a_we && WR_MODE == 1) ? bus.a_din : mem[bus.a_addr];
    assign b_rdata = !b_inr ? '0 : (bus.b_we && WR_MODE == 1) ? bus.b_din : mem[bus.b_addr];

    // Port A is written last so it wins a same-address double write
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (b_wr) mem[bus.b_addr] <= bus.b_din;
            if (a_wr) mem[bus.a_addr] <= bus.a_din;
        end
    end

    logic                 a_v1, b_v1;
    logic signed [DW-1:0] a_d1, b_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1      <= 1'b0;
            b_v1      <= 1'b0;
            a_d1      <= '0;
            b_d1      <= '0;
            collision <= 1'b0;
        end else begin
            a_v1      <= a_rd;
            b_v1      <= b_rd;
            if (a_rd) a_d1 <= a_rdata;
            if (b_rd) b_d1 <= b_rdata;
            collision <= a_acc && b_acc && (bus.a_addr == bus.b_addr) && (bus.a_we || bus.b_we);
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                 a_v2, b_v2;
            logic signed [DW-1:0] a_d2, b_d2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                    a_d2 <= '0;
                    b_d2 <= '0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) a_d2 <= a_d1;
                    if (b_v1) b_d2 <= b_d1;
                end
            end

            assign bus.a_valid = a_v2;
            assign bus.b_valid = b_v2;
            assign bus.a_dout  = a_d2;
            assign bus.b_dout  = b_d2;
        end else begin : g_lat1
            assign bus.a_valid = a_v1;
            assign bus.b_valid = b_v1;
            assign bus.a_dout  = a_d1;
            assign bus.b_dout  = b_d1;
        end
    endgenerate

endmodule

// File: tb/tb_bram_tdp_pipe.sv
// tb/tb_bram_tdp_pipe.sv - three parameterisations of bram_tdp_pipe driven in lockstep against a reference model
module tb_bram_tdp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_en, a_we, b_en, b_we, clr_req;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } rd_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // d0: READ_FIRST lat1 depth16; d1: WRITE_FIRST lat2 depth12; d2: NO_CHANGE lat2 depth16 no auto clear
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int DEP = (g == 1) ? 12 : 16;
        localparam int LAT = (g == 0) ? 1 : 2;
        localparam int COR = (g == 2) ? 0 : 1;

        logic busy, coll;
        bram_tdp_pipe_if #(.DW(16), .AW(4)) bus ();

        assign bus.a_en   = a_en;
        assign bus.a_we   = a_we;
        assign bus.a_addr = a_addr;
        assign bus.a_din  = a_din;
        assign bus.b_en   = b_en;
        assign bus.b_we   = b_we;
        assign bus.b_addr = b_addr;
        assign bus.b_din  = b_din;

        bram_tdp_pipe #(
            .DW(16), .DEPTH(DEP), .RD_LAT(LAT), .WR_MODE(g), .CLEAR_ON_RESET(COR)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus), .clr_req(clr_req), .busy(busy), .collision(coll)
        );

        logic [15:0] mem [16];
        int          clear_left = 0;
        int          ecount = 0;
        int          run = 0;
        bit          init_pend = 0;
        bit          exp_coll = 0;
        logic [15:0] last_a = '0, last_b = '0;
        rd_t         qa[$], qb[$];

        task automatic model_reset();
            clear_left = 0;
            init_pend  = (COR != 0);
            exp_coll   = 0;
            last_a     = '0;
            last_b     = '0;
            qa.delete();
            qb.delete();
        endtask

        task automatic model_edge();
            bit          a_in, b_in;
            logic [15:0] va, vb;
            ecount++;
            exp_coll = 0;
            if (clear_left == 0) begin
                a_in = int'(a_addr) < DEP;
                b_in = int'(b_addr) < DEP;
                va = !a_in ? 16'h0 : (a_we && g == 1) ? a_din : mem[a_addr];
                vb = !b_in ? 16'h0 : (b_we && g == 1) ? b_din : mem[b_addr];
                if (a_en && !(a_we && g == 2)) qa.push_back('{ecount + LAT - 1, va});
                if (b_en && !(b_we && g == 2)) qb.push_back('{ecount + LAT - 1, vb});
                exp_coll = a_en && b_en && (a_addr == b_addr) && (a_we || b_we);
                if (b_en && b_we && b_in) mem[b_addr] = b_din;
                if (a_en && a_we && a_in) mem[a_addr] = a_din;
                if (init_pend || clr_req) clear_left = DEP;
            end else begin
                mem[DEP - clear_left] = '0;
                clear_left--;
            end
            init_pend = 0;
        endtask

        always @(negedge rst_n) model_reset();

        always @(posedge clk) begin
            if (!rst_n) model_reset();
            else        model_edge();
        end

        always @(negedge clk) begin
            bit ea, eb;
            if (!rst_n) begin
                run = 0;
                check_eq($sformatf("d%0d rst a_dout", g),  32'($unsigned(bus.a_dout)), 32'h0);
                check_eq($sformatf("d%0d rst b_dout", g),  32'($unsigned(bus.b_dout)), 32'h0);
                check_eq($sformatf("d%0d rst a_valid", g), 32'(bus.a_valid), 32'h0);
                check_eq($sformatf("d%0d rst b_valid", g), 32'(bus.b_valid), 32'h0);
                check_eq($sformatf("d%0d rst busy", g),    32'(busy), 32'h0);
                check_eq($sformatf("d%0d rst coll", g),    32'(coll), 32'h0);
            end else begin
                ea = 0;
                eb = 0;
                if (qa.size() > 0 && qa[0].due == ecount) begin
                    ea = 1;
                    last_a = qa[0].dat;
                    void'(qa.pop_front());
                end
                if (qb.size() > 0 && qb[0].due == ecount) begin
                    eb = 1;
                    last_b = qb[0].dat;
                    void'(qb.pop_front());
                end
                check_eq($sformatf("d%0d a_valid @%0d", g, ecount), 32'(bus.a_valid), 32'(ea));
                check_eq($sformatf("d%0d b_valid @%0d", g, ecount), 32'(bus.b_valid), 32'(eb));
                check_eq($sformatf("d%0d a_dout @%0d", g, ecount),  32'($unsigned(bus.a_dout)), 32'(last_a));
                check_eq($sformatf("d%0d b_dout @%0d", g, ecount),  32'($unsigned(bus.b_dout)), 32'(last_b));
                check_eq($sformatf("d%0d busy @%0d", g, ecount),    32'(busy), 32'(clear_left > 0));
                check_eq($sformatf("d%0d coll @%0d", g, ecount),    32'(coll), 32'(exp_coll));
                if (busy) begin
                    run++;
                end else if (run > 0) begin
                    check_eq($sformatf("d%0d busy_len", g), 32'(run), 32'(DEP));
                    run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_en = 0; a_we = 0; b_en = 0; b_we = 0; clr_req = 0;
    endtask

    task automatic drive(input bit ae, input bit aw, input int aa, input int ad,
                         input bit be, input bit bw, input int ba, input int bd);
        a_en = ae; a_we = aw; a_addr = 4'(aa); a_din = 16'(ad);
        b_en = be; b_we = bw; b_addr = 4'(ba); b_din = 16'(bd);
        step();
        idle_in();
    endtask

    task automatic rand_cycle(input int clr_odds);
        a_en    = 1'($urandom_range(0, 1));
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = 4'($urandom_range(0, 15));
        a_din   = 16'($urandom);
        b_en    = 1'($urandom_range(0, 1));
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom_range(0, 15));
        b_din   = 16'($urandom);
        clr_req = ($urandom_range(0, clr_odds - 1) == 0);
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((gen_dut[0].busy || gen_dut[1].busy || gen_dut[2].busy) && n < 100) begin
            step();
            n++;
        end
        check_eq("wait_idle_bound", 32'(n >= 100), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_in();
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wait_idle();

        for (int i = 0; i < 16; i++) drive(1, 0, i, 0, 1, 0, 15 - i, 0);

        drive(1, 1, 5, 16'h1234, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 5, 0);
        step();

        drive(1, 1, 3, 16'h0011, 0, 0, 0, 0);
        drive(1, 1, 3, 16'h00FF, 0, 0, 0, 0);
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        step();

        drive(1, 1, 7, 16'h0AAA, 1, 1, 7, 16'h0BBB);
        step();
        drive(1, 0, 7, 0, 1, 0, 7, 0);
        step();

        drive(1, 1, 13, 16'h7FFF, 0, 0, 0, 0);
        drive(1, 0, 13, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(1, 0, i, 0, 1, 0, 11 - i, 0);

        for (int i = 0; i < 400; i++) rand_cycle(64);
        idle_in();
        repeat (3) step();
        wait_idle();

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) rand_cycle(4);
        idle_in();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) rand_cycle(4);
        idle_in();
        wait_idle();

        for (int i = 0; i < 16; i++) drive(1, 0, i, 0, 1, 0, 15 - i, 0);
        for (int i = 0; i < 200; i++) rand_cycle(64);
        idle_in();
        repeat (4) step();
        wait_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_tdp_pipe.md
BRAM_TDP_PIPE -- requirements
Module: bram_tdp_pipe

Interface
REQ-001 Parameter DW, 16, data width in bits (1..64).
REQ-002 Parameter DEPTH, 1024, number of words (2..65536, need not be a power of two).
REQ-003 Parameter AW, (DEPTH<=1)?1:$clog2(DEPTH), address width; derived, never overridden.
REQ-004 Parameter RD_LAT, 1, read latency in cycles; legal values 1 or 2, where 2 adds an output register.
REQ-005 Parameter WR_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
REQ-006 Parameter CLEAR_ON_RESET, 1, when 1 the block zero-fills memory automatically after reset release.
REQ-007 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Ports a_en / b_en, input, 1, access request, port A / port B.
REQ-010 Ports a_we / b_we, input, 1, write enable, qualified by the matching en.
REQ-011 Ports a_addr / b_addr, input, AW, word address.
REQ-012 Ports a_din / b_din, input, DW signed, write data.
REQ-013 Ports a_dout / b_dout, output, DW signed, read data.
REQ-014 Ports a_valid / b_valid, output, 1, one-cycle pulse marking new dout.
REQ-015 Port clr_req, input, 1, single-cycle request for a full zero-fill.
REQ-016 Port busy, output, 1, high while a clear is in progress.
REQ-017 Port collision, output, 1, registered pulse flagging a same-address conflict.

Function
REQ-018 Clear FSM: states IDLE and CLEAR only.
REQ-019 IDLE->CLEAR on clr_req=1 in IDLE, or on the first clk after rst_n release when CLEAR_ON_RESET=1.
REQ-020 In CLEAR, an internal counter writes 0 to address 0..DEPTH-1, one word per cycle, then returns to IDLE; a clear takes exactly DEPTH cycles.
REQ-021 busy=1 in every CLEAR cycle; busy=0 in IDLE.
REQ-022 While busy=1, all user requests are dropped: no writes, no valid pulses, dout held.
REQ-023 clr_req received while busy=1 is ignored and is not queued.
REQ-024 An accepted read (en=1, busy=0) places mem[addr] on dout exactly RD_LAT cycles later, with valid=1 for that cycle only.
REQ-025 dout holds its last value when no valid pulse occurs.
REQ-026 Both ports accept one request per cycle with no stall; back-to-back reads yield back-to-back valid pulses.
REQ-027 Same-port write with WR_MODE=0: dout returns the old word and valid pulses.
REQ-028 Same-port write with WR_MODE=1: dout returns din and valid pulses.
REQ-029 Same-port write with WR_MODE=2: no valid pulse and dout unchanged.
REQ-030 addr>=DEPTH: any write is dropped; a read returns 0 with a valid pulse per the mode rules.
REQ-031 A collision occurs when both ports are enabled, addresses are equal, and at least one we=1; collision then pulses 1 on the next cycle.
REQ-032 On collision, a cross-port read returns the pre-write word.
REQ-033 On collision with both ports writing, port A's data is stored.
REQ-034 Memory contents are not reset except by the clear engine.

Reset
REQ-035 rst_n=0 immediately forces a_dout=0, b_dout=0, a_valid=0, b_valid=0, collision=0, busy=0, FSM=IDLE, clear counter=0, and empties the pipeline registers.
REQ-036 Reset during CLEAR aborts the fill; after release the clear restarts from address 0 if CLEAR_ON_RESET=1, otherwise the FSM stays IDLE with memory partly cleared.

Verification
REQ-037 CLEAR_ON_RESET=1, DEPTH=16: release rst_n -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 0.
REQ-038 RD_LAT=2: write A[5]=0x1234, then read B[5] -> b_dout=0x1234 with b_valid exactly 2 cycles after the request.
REQ-039 WR_MODE=0/1/2, mem[3]=0x0011, port A writes 0x00FF to 3 -> a_dout is 0x0011 / 0x00FF / unchanged with no a_valid, respectively.
REQ-040 A and B both write address 7 (A=0x0AAA, B=0x0BBB) in the same cycle -> collision pulses once and a later read of 7 returns 0x0AAA.
REQ-041 DEPTH=12, write 0x7FFF to address 13, then read address 13 -> a_dout=0 and mem[0..11] unchanged.
REQ-042 Assert rst_n=0 at clear cycle 5, then release -> outputs 0 during reset; busy resumes and runs the full DEPTH cycles; clr_req while busy has no extra effect.
